// File: rtl/complex_div_pkg.sv
`default_nettype none
// ============================================================================
// complex_div_pkg
// FSM states, width helpers and the signed-magnitude helper for complex_div.
// Honours COMPLEX_DIV_ROUND_EN (adds one guard iteration).
// Revision: 1.0
// ============================================================================
package complex_div_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        DIV  = 3'd2,
        FIN  = 3'd3,
        DONE = 3'd4
    } stateT;

    // Widest intermediate handled by condNeg; every datapath value fits in it.
    localparam int MAX_W = 64;

    function automatic int calcNumW(input int width);
        return 2 * width + 1;
    endfunction

    function automatic int calcDenW(input int width);
        return 2 * width + 1;
    endfunction

    function automatic int calcIter(input int width, input int frac);
`ifdef COMPLEX_DIV_ROUND_EN
        return 2 * width + frac + 1;
`else
        return 2 * width + frac;
`endif
    endfunction

    // abs() when neg is the value's own sign bit, sign re-application otherwise.
    function automatic logic [MAX_W-1:0] condNeg(input logic [MAX_W-1:0] value,
                                                 input logic neg);
        return neg ? (~value + MAX_W'(1)) : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/complex_div_step.sv
`default_nettype none
// ============================================================================
// unsigned_restoring_div_step
// One combinational restoring-division step: shift in a dividend bit, try to
// subtract the divisor, keep the difference when it does not borrow.
// Revision: 1.0
// ============================================================================
module unsigned_restoring_div_step #(
    parameter int W = 17
) (
    input  logic [W-1:0] remIn,
    input  logic         bitIn,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] remOut,
    output logic         qBit
);

    logic [W:0] w_shifted;
    logic [W:0] w_trial;

    // remIn < divisor < 2^(W-1), so bit W of the trial is a clean borrow flag.
    assign w_shifted = {remIn, bitIn};
    assign w_trial   = w_shifted - {1'b0, divisor};
    assign qBit      = ~w_trial[W];
    assign remOut    = qBit ? w_trial[W-1:0] : w_shifted[W-1:0];

endmodule
`default_nettype wire

// File: rtl/complex_div.sv
`default_nettype none
// ============================================================================
// complex_div
// Sequential signed complex divider q = a / b with valid/ready handshakes;
// two serial restoring-division lanes share the denominator |b|^2.
// Optional: define COMPLEX_DIV_ROUND_EN for round-to-nearest, ties away.
// Revision: 1.0
// ============================================================================
module complex_div
    import complex_div_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FRAC  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inValid,
    output logic               inReady,
    input  logic [WIDTH-1:0]   aReal,
    input  logic [WIDTH-1:0]   aImag,
    input  logic [WIDTH-1:0]   bReal,
    input  logic [WIDTH-1:0]   bImag,
    output logic               outValid,
    input  logic               outReady,
    output logic [2*WIDTH-1:0] outReal,
    output logic [2*WIDTH-1:0] outImag,
    output logic               divByZero
);

    localparam int NUM_W = calcNumW(WIDTH);
    localparam int DEN_W = calcDenW(WIDTH);
    localparam int ITER  = calcIter(WIDTH, FRAC);
    localparam int OUT_W = 2 * WIDTH;
    localparam int SHIFT = ITER - OUT_W;
    localparam int CNT_W = $clog2(ITER);

    stateT              r_state;
    logic [WIDTH-1:0]   r_aReal, r_aImag, r_bReal, r_bImag;
    logic               r_negReal, r_negImag, r_zeroDen;
    logic [DEN_W-1:0]   r_den;
    logic [ITER-1:0]    r_dvdReal, r_dvdImag;
    logic [DEN_W-1:0]   r_remReal, r_remImag;
    logic [ITER-1:0]    r_quoReal, r_quoImag;
    logic [CNT_W-1:0]   r_iter;
    logic               r_inReady, r_outValid, r_divByZero;
    logic [OUT_W-1:0]   r_outReal, r_outImag;

    logic signed [NUM_W-1:0] w_ar, w_ai, w_br, w_bi;
    logic signed [NUM_W-1:0] w_numReal, w_numImag, w_den;
    logic [MAX_W-1:0]   w_magNumReal, w_magNumImag, w_dvdReal64, w_dvdImag64;
    logic [DEN_W-1:0]   w_remRealNext, w_remImagNext;
    logic               w_qBitReal, w_qBitImag;
    logic [MAX_W-1:0]   w_quoReal64, w_quoImag64, w_magReal64, w_magImag64;
    logic [MAX_W-1:0]   w_resReal64, w_resImag64;
    logic               w_unusedBits;

    assign w_ar = {{(NUM_W-WIDTH){r_aReal[WIDTH-1]}}, r_aReal};
    assign w_ai = {{(NUM_W-WIDTH){r_aImag[WIDTH-1]}}, r_aImag};
    assign w_br = {{(NUM_W-WIDTH){r_bReal[WIDTH-1]}}, r_bReal};
    assign w_bi = {{(NUM_W-WIDTH){r_bImag[WIDTH-1]}}, r_bImag};

    assign w_numReal = w_ar * w_br + w_ai * w_bi;
    assign w_numImag = w_ai * w_br - w_ar * w_bi;
    assign w_den     = w_br * w_br + w_bi * w_bi;

    assign w_magNumReal = condNeg({{(MAX_W-NUM_W){w_numReal[NUM_W-1]}}, w_numReal},
                                  w_numReal[NUM_W-1]);
    assign w_magNumImag = condNeg({{(MAX_W-NUM_W){w_numImag[NUM_W-1]}}, w_numImag},
                                  w_numImag[NUM_W-1]);
    // |N| < 2^(2*WIDTH), so the low ITER bits hold the whole scaled dividend.
    assign w_dvdReal64 = w_magNumReal << SHIFT;
    assign w_dvdImag64 = w_magNumImag << SHIFT;

    unsigned_restoring_div_step #(.W(DEN_W)) u_stepReal (
        .remIn   (r_remReal),
        .bitIn   (r_dvdReal[ITER-1]),
        .divisor (r_den),
        .remOut  (w_remRealNext),
        .qBit    (w_qBitReal)
    );

    unsigned_restoring_div_step #(.W(DEN_W)) u_stepImag (
        .remIn   (r_remImag),
        .bitIn   (r_dvdImag[ITER-1]),
        .divisor (r_den),
        .remOut  (w_remImagNext),
        .qBit    (w_qBitImag)
    );

    assign w_quoReal64 = {{(MAX_W-ITER){1'b0}}, r_quoReal};
    assign w_quoImag64 = {{(MAX_W-ITER){1'b0}}, r_quoImag};
`ifdef COMPLEX_DIV_ROUND_EN
    // Guard bit set means the dropped fraction is >= 1/2 of an LSB.
    assign w_magReal64 = (w_quoReal64 >> 1) + {{(MAX_W-1){1'b0}}, r_quoReal[0]};
    assign w_magImag64 = (w_quoImag64 >> 1) + {{(MAX_W-1){1'b0}}, r_quoImag[0]};
`else
    assign w_magReal64 = w_quoReal64;
    assign w_magImag64 = w_quoImag64;
`endif
    assign w_resReal64 = condNeg(w_magReal64, r_negReal);
    assign w_resImag64 = condNeg(w_magImag64, r_negImag);

    assign w_unusedBits = ^{w_dvdReal64[MAX_W-1:ITER], w_dvdImag64[MAX_W-1:ITER],
                            w_resReal64[MAX_W-1:OUT_W], w_resImag64[MAX_W-1:OUT_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_aReal     <= '0;
            r_aImag     <= '0;
            r_bReal     <= '0;
            r_bImag     <= '0;
            r_negReal   <= 1'b0;
            r_negImag   <= 1'b0;
            r_zeroDen   <= 1'b0;
            r_den       <= '0;
            r_dvdReal   <= '0;
            r_dvdImag   <= '0;
            r_remReal   <= '0;
            r_remImag   <= '0;
            r_quoReal   <= '0;
            r_quoImag   <= '0;
            r_iter      <= '0;
            r_inReady   <= 1'b1;
            r_outValid  <= 1'b0;
            r_outReal   <= '0;
            r_outImag   <= '0;
            r_divByZero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (inValid) begin
                        r_aReal   <= aReal;
                        r_aImag   <= aImag;
                        r_bReal   <= bReal;
                        r_bImag   <= bImag;
                        r_inReady <= 1'b0;
                        r_state   <= LOAD;
                    end
                end
                LOAD: begin
                    r_negReal <= w_numReal[NUM_W-1];
                    r_negImag <= w_numImag[NUM_W-1];
                    r_den     <= w_den;
                    r_zeroDen <= (w_den == '0);
                    r_dvdReal <= w_dvdReal64[ITER-1:0];
                    r_dvdImag <= w_dvdImag64[ITER-1:0];
                    r_remReal <= '0;
                    r_remImag <= '0;
                    r_quoReal <= '0;
                    r_quoImag <= '0;
                    r_iter    <= '0;
                    r_state   <= DIV;
                end
                DIV: begin
                    // A zero divisor would make every step succeed; lanes stay at 0.
                    if (!r_zeroDen) begin
                        r_remReal <= w_remRealNext;
                        r_remImag <= w_remImagNext;
                        r_quoReal <= {r_quoReal[ITER-2:0], w_qBitReal};
                        r_quoImag <= {r_quoImag[ITER-2:0], w_qBitImag};
                        r_dvdReal <= {r_dvdReal[ITER-2:0], 1'b0};
                        r_dvdImag <= {r_dvdImag[ITER-2:0], 1'b0};
                    end
                    r_iter <= r_iter + CNT_W'(1);
                    if (r_iter == CNT_W'(ITER - 1)) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_outReal   <= r_zeroDen ? '0 : w_resReal64[OUT_W-1:0];
                    r_outImag   <= r_zeroDen ? '0 : w_resImag64[OUT_W-1:0];
                    r_divByZero <= r_zeroDen;
                    r_state     <= DONE;
                end
                DONE: begin
                    // Results settle one cycle before outValid is presented.
                    if (!r_outValid) begin
                        r_outValid <= 1'b1;
                    end else if (outReady) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign inReady   = r_inReady;
    assign outValid  = r_outValid;
    assign outReal   = r_outReal;
    assign outImag   = r_outImag;
    assign divByZero = r_divByZero;

endmodule
`default_nettype wire

// File: tb/tb_complex_div.sv
`default_nettype none
// ============================================================================
// tb_complex_div
// Directed self-checking bench for complex_div at default parameters.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_complex_div;

    localparam int WIDTH = 8;
    localparam int FRAC  = 4;
`ifdef COMPLEX_DIV_ROUND_EN
    localparam int LAT       = 24;
    localparam int TWO_THIRD = 11;
    localparam int NEG_SAT   = -16;
`else
    localparam int LAT       = 23;
    localparam int TWO_THIRD = 10;
    localparam int NEG_SAT   = -15;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               inValid;
    logic               inReady;
    logic [WIDTH-1:0]   aReal, aImag, bReal, bImag;
    logic               outValid;
    logic               outReady;
    logic [2*WIDTH-1:0] outReal, outImag;
    logic               divByZero;

    int nCompared   = 0;
    int nMismatched = 0;

    complex_div #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst       (rst),
        .inValid   (inValid),
        .inReady   (inReady),
        .aReal     (aReal),
        .aImag     (aImag),
        .bReal     (bReal),
        .bImag     (bImag),
        .outValid  (outValid),
        .outReady  (outReady),
        .outReal   (outReal),
        .outImag   (outImag),
        .divByZero (divByZero)
    );

    always #5 clk = ~clk;

    // Issues one operation with outReady high; returns results and latency (-1 on timeout).
    task automatic doOp(input int ar, input int ai, input int br, input int bi,
                        output logic [15:0] gr, output logic [15:0] gi,
                        output logic gz, output int lat);
        lat = -1;
        for (int i = 0; i < 50 && !inReady; i++) begin
            @(posedge clk); #1;
        end
        aReal = 8'(ar); aImag = 8'(ai); bReal = 8'(br); bImag = 8'(bi);
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (outValid) begin
                lat = c;
                break;
            end
        end
        gr = outReal;
        gi = outImag;
        gz = divByZero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; inValid = 1'b0; outReady = 1'b1;
        aReal = '0; aImag = '0; bReal = '0; bImag = '0;
        #12;
        nCompared++;
        if (inReady !== 1'b1) begin nMismatched++; $display("FAIL reset_inReady: got %b want 1", inReady); end
        nCompared++;
        if (outValid !== 1'b0) begin nMismatched++; $display("FAIL reset_outValid: got %b want 0", outValid); end
        nCompared++;
        if (outReal !== 16'd0 || outImag !== 16'd0) begin
            nMismatched++; $display("FAIL reset_outputs: got %0d/%0d want 0/0", $signed(outReal), $signed(outImag));
        end
        nCompared++;
        if (divByZero !== 1'b0) begin nMismatched++; $display("FAIL reset_divByZero: got %b want 0", divByZero); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] gr, gi; logic gz; int lat;
        doOp(3, 4, 1, 2, gr, gi, gz, lat);
        nCompared++;
        if (gr !== 16'(35)) begin nMismatched++; $display("FAIL basic_real: got %0d want 35", $signed(gr)); end
        nCompared++;
        if (gi !== 16'(-6)) begin nMismatched++; $display("FAIL basic_imag: got %0d want -6", $signed(gi)); end
        nCompared++;
        if (gz !== 1'b0) begin nMismatched++; $display("FAIL basic_dbz: got %b want 0", gz); end
        nCompared++;
        if (lat != LAT) begin nMismatched++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        nCompared++;
        if (inReady !== 1'b1) begin nMismatched++; $display("FAIL basic_inReady_after: got %b want 1", inReady); end
    endtask

    task automatic test_fraction();
        logic [15:0] gr, gi; logic gz; int lat;
        doOp(1, 0, 3, 0, gr, gi, gz, lat);
        nCompared++;
        if (gr !== 16'(5) || gi !== 16'(0)) begin
            nMismatched++; $display("FAIL third: got %0d/%0d want 5/0", $signed(gr), $signed(gi));
        end
        doOp(2, 0, 3, 0, gr, gi, gz, lat);
        nCompared++;
        if (gr !== 16'(TWO_THIRD)) begin
            nMismatched++; $display("FAIL two_thirds: got %0d want %0d", $signed(gr), TWO_THIRD);
        end
        nCompared++;
        if (lat != LAT) begin nMismatched++; $display("FAIL two_thirds_latency: got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_extremes();
        logic [15:0] gr, gi; logic gz; int lat;
        doOp(-128, -128, 1, 0, gr, gi, gz, lat);
        nCompared++;
        if (gr !== 16'(-2048) || gi !== 16'(-2048)) begin
            nMismatched++; $display("FAIL min_by_one: got %0d/%0d want -2048/-2048", $signed(gr), $signed(gi));
        end
        doOp(127, 127, -128, 0, gr, gi, gz, lat);
        nCompared++;
        if (gr !== 16'(NEG_SAT) || gi !== 16'(NEG_SAT)) begin
            nMismatched++; $display("FAIL max_by_min: got %0d/%0d want %0d/%0d", $signed(gr), $signed(gi), NEG_SAT, NEG_SAT);
        end
    endtask

    task automatic test_div_by_zero();
        logic [15:0] gr, gi; logic gz; int lat;
        doOp(5, 5, 0, 0, gr, gi, gz, lat);
        nCompared++;
        if (gz !== 1'b1) begin nMismatched++; $display("FAIL dbz_flag: got %b want 1", gz); end
        nCompared++;
        if (gr !== 16'd0 || gi !== 16'd0) begin
            nMismatched++; $display("FAIL dbz_outputs: got %0d/%0d want 0/0", $signed(gr), $signed(gi));
        end
        nCompared++;
        if (lat != LAT) begin nMismatched++; $display("FAIL dbz_latency: got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] gr, gi; logic gz; int lat;
        lat = -1;
        outReady = 1'b0;
        aReal = 8'd3; aImag = 8'd4; bReal = 8'd1; bImag = 8'd2;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (outValid) begin lat = c; break; end
        end
        nCompared++;
        if (lat != LAT) begin nMismatched++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                aReal = 8'd1; aImag = 8'd0; bReal = 8'd3; bImag = 8'd0;
                inValid = 1'b1;
            end else begin
                inValid = 1'b0;
            end
            @(posedge clk); #1;
            nCompared++;
            if (outValid !== 1'b1 || inReady !== 1'b0 || outReal !== 16'(35) || outImag !== 16'(-6)) begin
                nMismatched++;
                $display("FAIL b2b_hold[%0d]: got v=%b r=%b %0d/%0d want v=1 r=0 35/-6",
                         k, outValid, inReady, $signed(outReal), $signed(outImag));
            end
        end
        inValid = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        nCompared++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            nMismatched++; $display("FAIL b2b_handshake: got v=%b r=%b want v=0 r=1", outValid, inReady);
        end
        doOp(-128, -128, 1, 0, gr, gi, gz, lat);
        nCompared++;
        if (gr !== 16'(-2048) || gi !== 16'(-2048) || lat != LAT) begin
            nMismatched++; $display("FAIL b2b_second: got %0d/%0d lat %0d want -2048/-2048 lat %0d",
                                    $signed(gr), $signed(gi), lat, LAT);
        end
    endtask

    task automatic test_reset_mid_div();
        logic [15:0] gr, gi; logic gz; int lat;
        outReady = 1'b1;
        aReal = 8'd2; aImag = 8'd0; bReal = 8'd3; bImag = 8'd0;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        nCompared++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            nMismatched++; $display("FAIL midrst_flags: got v=%b r=%b want v=0 r=1", outValid, inReady);
        end
        nCompared++;
        if (outReal !== 16'd0 || outImag !== 16'd0) begin
            nMismatched++; $display("FAIL midrst_outputs: got %0d/%0d want 0/0", $signed(outReal), $signed(outImag));
        end
        #3 rst = 1'b0;
        @(posedge clk); #1;
        doOp(3, 4, 1, 2, gr, gi, gz, lat);
        nCompared++;
        if (gr !== 16'(35) || gi !== 16'(-6) || gz !== 1'b0 || lat != LAT) begin
            nMismatched++; $display("FAIL midrst_recover: got %0d/%0d dbz %b lat %0d want 35/-6 dbz 0 lat %0d",
                                    $signed(gr), $signed(gi), gz, lat, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fraction();
        test_extremes();
        test_div_by_zero();
        test_back_to_back();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/complex_div.md
Name: complex_div

Overview:
- Sequential signed complex divider: q = a / b, where a = aReal + j·aImag and b = bReal + j·bImag.
- Computed as q = ((ar·br + ai·bi) + j·(ai·br − ar·bi)) / (br² + bi²).
- Inverse companion to the complex multiplier; sits in the same fixed-point datapath (equalisation/normalisation).
- Valid/ready on both sides; one shared denominator, two serial restoring-division lanes.

Parameters:
- WIDTH, 8, bit width of each signed two's-complement input component.
- FRAC, 4, fractional bits of the quotient; legal range 0..WIDTH-1. Guarantees no output overflow.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- inValid  input  1  operands valid.
- inReady  output  1  block can accept operands.
- aReal  input  WIDTH  dividend real part, signed.
- aImag  input  WIDTH  dividend imaginary part, signed.
- bReal  input  WIDTH  divisor real part, signed.
- bImag  input  WIDTH  divisor imaginary part, signed.
- outValid  output  1  result valid.
- outReady  input  1  consumer accepts result.
- outReal  output  2*WIDTH  quotient real part, signed, FRAC fractional bits.
- outImag  output  2*WIDTH  quotient imaginary part, signed, FRAC fractional bits.
- divByZero  output  1  qualifies the result: divisor was 0+0j.

Behaviour:
- Reset (async, active-high):
  - state = IDLE; inReady = 1; outValid = 0; outReal = outImag = 0; divByZero = 0.
  - Takes effect immediately, including mid-operation. Any in-flight result is discarded.
- inReady = (state == IDLE). Operands are captured on the edge where inValid & inReady. inValid while busy is ignored; there is no queueing.
- States:
  - IDLE → LOAD on accept.
  - LOAD, 1 cycle: register numerators Nr = ar·br + ai·bi and Ni = ai·br − ar·bi, each 2*WIDTH+1 bits signed. Register D = br² + bi², 2*WIDTH+1 bits unsigned. Store sign(Nr), sign(Ni) and |Nr|, |Ni|.
  - DIV, ITER = 2*WIDTH+FRAC cycles: both lanes run one restoring-division step per cycle on dividend |N|<<FRAC, MSB first, with shared divisor D. Iteration counter runs 0..ITER-1.
  - FIN, 1 cycle: keep the low 2*WIDTH quotient bits (upper bits are provably 0). Negate if the stored sign is set. Register outReal and outImag.
  - DONE: outValid = 1. Outputs and divByZero stay stable until outValid & outReady, then → IDLE. inReady rises the following cycle.
- Latency: outValid rises ITER+3 cycles after the accept edge (23 cycles at defaults). The latency is fixed and data-independent.
- Rounding: truncation toward zero, applied to each component independently.
- Divide by zero (D == 0):
  - divByZero = 1; outReal = outImag = 0.
  - Same latency. The FSM still walks through DIV; the lanes are held.
- Output range: |component| ≤ √2·2^(WIDTH-1+FRAC) < 2^(2*WIDTH-1). No saturation logic is needed.
- outReady asserted before outValid has no effect.

Optional Feature:
- Macro: COMPLEX_DIV_ROUND_EN.
- Defined:
  - ITER = 2*WIDTH+FRAC+1; one guard bit is computed.
  - Magnitude is rounded to nearest, ties away from zero (add the guard bit, then drop it), before the sign is applied.
  - Latency becomes ITER+3 = 24 cycles at defaults.
  - The range bound still holds.
- Undefined: truncation toward zero, as above.

Decomposition:
- Package complex_div_pkg holds:
  - state enum (IDLE, LOAD, DIV, FIN, DONE);
  - localparam widths: NUM_W = 2*WIDTH+1, DEN_W = 2*WIDTH+1, ITER;
  - a signed-magnitude helper function (abs, conditional negate).
- Sub-module: unsigned_restoring_div_step.
  - Combinational one-bit step: partial remainder and divisor in; new remainder and quotient bit out.
  - Instantiated twice (real lane, imag lane); the FSM and registers stay in complex_div.

Test Plan:
- (3+4j)/(1+2j), defaults → outReal=35, outImag=-6, divByZero=0. outValid exactly 23 cycles after accept.
- (1+0j)/(3+0j) → outReal=5. (2+0j)/(3+0j) → outReal=10 without COMPLEX_DIV_ROUND_EN, 11 with it, at 24-cycle latency.
- (-128-128j)/(1+0j) → outReal=-2048, outImag=-2048. (127+127j)/(-128+0j) → outReal=-15, outImag=-15.
- b=0+0j, a=5+5j → divByZero=1, outReal=outImag=0, latency 23.
- Back-to-back:
  - Hold outReady=0 for 10 cycles after outValid: outputs stable, inReady=0.
  - Pulse inValid with new operands during that window: ignored.
  - Raise outReady: one handshake, inReady=1 next cycle, second operation accepted and correct.
- Assert rst during DIV at iteration 7:
  - outValid=0 and inReady=1 immediately (async).
  - After release, a fresh (3+4j)/(1+2j) returns 35/-6 at nominal latency.
